// File: rtl/peak_phase_diff_if.sv
// Bus bundle for peak_phase_diff: polar bin stream in, per-frame peak result out.
// Optional feature macro: PEAK_PHASE_THRESH_EN (adds mag_thresh_in).
interface peak_phase_diff_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FFT_LEN    = 1024
);
  localparam int BIN_W = $clog2(FFT_LEN);

  logic [DATA_WIDTH-1:0] data_in [CHANNELS];
  logic                  valid_in;
`ifdef PEAK_PHASE_THRESH_EN
  logic [15:0]           mag_thresh_in;
`endif
  logic signed [15:0]    phase_diff_out [CHANNELS-1];
  logic [BIN_W-1:0]      peak_bin_out;
  logic [15:0]           peak_mag_out;
  logic                  valid_out;

`ifdef PEAK_PHASE_THRESH_EN
  modport master (output data_in, valid_in, mag_thresh_in,
                  input  phase_diff_out, peak_bin_out, peak_mag_out, valid_out);
  modport slave  (input  data_in, valid_in, mag_thresh_in,
                  output phase_diff_out, peak_bin_out, peak_mag_out, valid_out);
`else
  modport master (output data_in, valid_in,
                  input  phase_diff_out, peak_bin_out, peak_mag_out, valid_out);
  modport slave  (input  data_in, valid_in,
                  output phase_diff_out, peak_bin_out, peak_mag_out, valid_out);
`endif
endinterface

// File: rtl/peak_phase_diff.sv
// Per-frame channel-0 peak picker with wrapped inter-channel phase differences.
// Optional feature macro: PEAK_PHASE_THRESH_EN (suppress frames whose peak
// magnitude is below mag_thresh_in; outputs keep their previous values).
module peak_phase_diff #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FFT_LEN    = 1024,
  parameter int MIN_BIN    = 1,
  parameter int MAX_BIN    = 511
) (
  input logic             clk_in,
  input logic             rst_in,
  peak_phase_diff_if.slave io
);
  localparam int BIN_W = $clog2(FFT_LEN);
  localparam logic [BIN_W-1:0]   LAST_BIN = BIN_W'(FFT_LEN - 1);
  localparam logic signed [16:0] PI       = 17'sd25736;
  localparam logic signed [16:0] TWO_PI   = 17'sd51472;

  logic [BIN_W-1:0]   bin_cnt;

  logic               srch_seen;
  logic [BIN_W-1:0]   srch_bin;
  logic [15:0]        srch_mag;
  logic [15:0]        srch_ph [CHANNELS];

  logic               hold_vld;
  logic               hold_seen;
  logic [BIN_W-1:0]   hold_bin;
  logic [15:0]        hold_mag;
  logic [15:0]        hold_ph [CHANNELS];

  logic [15:0]        mag0;
  logic               in_win;
  logic               upd;
  logic               last;
  logic               nxt_seen;
  logic [BIN_W-1:0]   nxt_bin;
  logic [15:0]        nxt_mag;
  logic [15:0]        nxt_ph [CHANNELS];
  logic signed [16:0] diff [CHANNELS-1];
  logic               thresh_ok;

  // Search decision for the current sample and the search state it produces.
  always_comb begin
    mag0     = io.data_in[0][15:0];
    in_win   = io.valid_in && (int'(bin_cnt) >= MIN_BIN) && (int'(bin_cnt) <= MAX_BIN);
    upd      = in_win && (!srch_seen || (mag0 > srch_mag));
    last     = io.valid_in && (bin_cnt == LAST_BIN);
    nxt_seen = srch_seen | upd;
    nxt_bin  = upd ? bin_cnt : srch_bin;
    nxt_mag  = upd ? mag0 : srch_mag;
    for (int c = 0; c < CHANNELS; c++)
      nxt_ph[c] = upd ? io.data_in[c][31:16] : srch_ph[c];
  end

  // Wrapped phase difference of each channel against channel 0, from the hold stage.
  always_comb begin
    for (int k = 1; k < CHANNELS; k++) begin
      diff[k-1] = $signed({hold_ph[k][15], hold_ph[k]}) - $signed({hold_ph[0][15], hold_ph[0]});
      if (diff[k-1] > PI)
        diff[k-1] = diff[k-1] - TWO_PI;
      else if (diff[k-1] < -PI)
        diff[k-1] = diff[k-1] + TWO_PI;
    end
  end

  // Frame gating on peak magnitude (always open when the feature is absent).
  always_comb begin
`ifdef PEAK_PHASE_THRESH_EN
    thresh_ok = (hold_mag >= io.mag_thresh_in);
`else
    thresh_ok = 1'b1;
`endif
  end

  // Bin counter; advances only on accepted samples and wraps at the frame end.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      bin_cnt <= '0;
    else if (io.valid_in)
      bin_cnt <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + 1'b1;
  end

  // Running search; at the last bin its final state moves to the hold stage and it clears.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      srch_seen <= 1'b0;
      srch_bin  <= '0;
      srch_mag  <= '0;
      hold_vld  <= 1'b0;
      hold_seen <= 1'b0;
      hold_bin  <= '0;
      hold_mag  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        srch_ph[c] <= '0;
        hold_ph[c] <= '0;
      end
    end else begin
      hold_vld <= last;
      if (last) begin
        hold_seen <= nxt_seen;
        hold_bin  <= nxt_bin;
        hold_mag  <= nxt_mag;
        srch_seen <= 1'b0;
        srch_bin  <= '0;
        srch_mag  <= '0;
        for (int c = 0; c < CHANNELS; c++) begin
          hold_ph[c] <= nxt_ph[c];
          srch_ph[c] <= '0;
        end
      end else if (upd) begin
        srch_seen <= 1'b1;
        srch_bin  <= bin_cnt;
        srch_mag  <= mag0;
        for (int c = 0; c < CHANNELS; c++)
          srch_ph[c] <= nxt_ph[c];
      end
    end
  end

  // Output registers: one-cycle valid pulse per reported frame, data held in between.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      io.valid_out    <= 1'b0;
      io.peak_bin_out <= '0;
      io.peak_mag_out <= '0;
      for (int k = 0; k < CHANNELS - 1; k++)
        io.phase_diff_out[k] <= '0;
    end else begin
      io.valid_out <= 1'b0;
      if (hold_vld && thresh_ok) begin
        io.valid_out    <= 1'b1;
        io.peak_bin_out <= hold_seen ? hold_bin : BIN_W'(MIN_BIN);
        io.peak_mag_out <= hold_seen ? hold_mag : 16'd0;
        for (int k = 0; k < CHANNELS - 1; k++)
          io.phase_diff_out[k] <= diff[k][15:0];
      end
    end
  end
endmodule

// File: tb/tb_peak_phase_diff.sv
// Bench for peak_phase_diff: FFT_LEN=16, window 1..7, four channels.
// Covers PEAK_PHASE_THRESH_EN frames when that macro is defined.
`timescale 1ns/1ps
module tb_peak_phase_diff;
  localparam int CH = 4, DW = 32, FL = 16, MINB = 1, MAXB = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  peak_phase_diff_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .FFT_LEN(FL)) io();

  peak_phase_diff #(.CHANNELS(CH), .DATA_WIDTH(DW), .FFT_LEN(FL),
                    .MIN_BIN(MINB), .MAX_BIN(MAXB)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .io    (io)
  );

  typedef struct packed {
    int               bin;
    int               mag;
    logic [2:0][15:0] d;
    int               due;
  } exp_t;

  typedef struct packed {
    int               pk_bin;
    int               pk_mag;
    int               alt_bin;
    int               alt_mag;
    logic [3:0][15:0] ph;
    int               eb;
    int               em;
    logic [2:0][15:0] ed;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  exp_t        q[$];
  exp_t        last_exp = '0;
  exp_t        exp_next = '0;
  exp_t        got_e;
  logic        push_en = 1'b1;
  logic [15:0] fr_mag [FL];
  logic [15:0] fr_ph  [FL][CH];
  vec_t        vecs [7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Spec-level phase difference: signed difference folded into [-pi, pi].
  function automatic logic [15:0] wrapd(input logic [15:0] p0, input logic [15:0] pk);
    int d;
    d = int'($signed(pk)) - int'($signed(p0));
    if (d > 25736) d -= 51472;
    else if (d < -25736) d += 51472;
    return d[15:0];
  endfunction

  // Reference: first maximum of channel-0 magnitude inside the window.
  function automatic void model();
    int best, bb;
    best = -1;
    bb   = MINB;
    for (int b = MINB; b <= MAXB; b++)
      if (best < 0 || int'(fr_mag[b]) > best) begin
        best = int'(fr_mag[b]);
        bb   = b;
      end
    exp_next.bin = bb;
    exp_next.mag = best;
    for (int k = 1; k < CH; k++)
      exp_next.d[k-1] = wrapd(fr_ph[bb][0], fr_ph[bb][k]);
  endfunction

  function automatic vec_t mkvec(input int pb, input int pm, input int ab, input int am,
                                 input int p0, input int p1, input int p2, input int p3,
                                 input int eb, input int em, input int d1, input int d2, input int d3);
    vec_t v;
    v.pk_bin = pb; v.pk_mag = pm; v.alt_bin = ab; v.alt_mag = am;
    v.ph[0] = 16'(p0); v.ph[1] = 16'(p1); v.ph[2] = 16'(p2); v.ph[3] = 16'(p3);
    v.eb = eb; v.em = em;
    v.ed[0] = 16'(d1); v.ed[1] = 16'(d2); v.ed[2] = 16'(d3);
    return v;
  endfunction

  task automatic build_dir(input vec_t v);
    for (int b = 0; b < FL; b++) begin
      fr_mag[b] = 16'd10;
      for (int c = 0; c < CH; c++) fr_ph[b][c] = 16'(37 * b * (c + 1));
    end
    fr_mag[v.alt_bin] = 16'(v.alt_mag);
    for (int c = 0; c < CH; c++) fr_ph[v.alt_bin][c] = 16'(-3000 + c);
    fr_mag[v.pk_bin] = 16'(v.pk_mag);
    for (int c = 0; c < CH; c++) fr_ph[v.pk_bin][c] = v.ph[c];
    exp_next.bin = v.eb;
    exp_next.mag = v.em;
    exp_next.d   = v.ed;
  endtask

  task automatic rand_frame(input int maxmag);
    for (int b = 0; b < FL; b++) begin
      fr_mag[b] = 16'($urandom_range(0, maxmag));
      for (int c = 0; c < CH; c++) fr_ph[b][c] = 16'($urandom_range(0, 65535));
    end
    model();
  endtask

  task automatic drive_frame(input int nbins, input int max_gap);
    int g;
    for (int b = 0; b < nbins; b++) begin
      g = (max_gap > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, max_gap) : 0;
      repeat (g) begin
        @(posedge clk); #1;
        io.valid_in = 1'b0;
      end
      @(posedge clk); #1;
      io.valid_in = 1'b1;
      for (int c = 0; c < CH; c++)
        io.data_in[c] = {fr_ph[b][c], (c == 0) ? fr_mag[b] : 16'($urandom)};
      if (b == FL - 1) begin
        exp_next.due = cyc + 2;
        if (push_en) q.push_back(exp_next);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      io.valid_in = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(io.valid_out), 0);
    check({tag, "_bin"}, int'(io.peak_bin_out), 0);
    check({tag, "_mag"}, int'(io.peak_mag_out), 0);
    for (int k = 0; k < CH - 1; k++)
      check({tag, "_diff"}, int'(io.phase_diff_out[k]), 0);
  endtask

  // Output monitor: every pulse must match the next expected frame; outputs hold otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (io.valid_out) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", int'(io.valid_out), 0);
        end else begin
          got_e = q.pop_front();
          check("latency", cyc, got_e.due);
          check("peak_bin", int'(io.peak_bin_out), got_e.bin);
          check("peak_mag", int'(io.peak_mag_out), got_e.mag);
          for (int k = 0; k < CH - 1; k++)
            check("phase_diff", int'(io.phase_diff_out[k]), int'($signed(got_e.d[k])));
          last_exp = got_e;
        end
      end else begin
        check("hold_bin", int'(io.peak_bin_out), last_exp.bin);
        check("hold_mag", int'(io.peak_mag_out), last_exp.mag);
        check("hold_diff1", int'(io.phase_diff_out[0]), int'($signed(last_exp.d[0])));
      end
    end
  end

  initial begin
    io.valid_in = 1'b0;
    for (int c = 0; c < CH; c++) io.data_in[c] = '0;
`ifdef PEAK_PHASE_THRESH_EN
    io.mag_thresh_in = 16'd0;
`endif
    //           pk  mag    alt mag    ph0     ph1     ph2     ph3   eb  em     d1      d2      d3
    vecs[0] = mkvec(5, 1000, 12, 10,    0,      4096,  -4096,  25000, 5, 1000,  4096,  -4096,  25000);
    vecs[1] = mkvec(5, 1000, 12, 10,    25000, -25000,  0,     0,     5, 1000,  1472,  -25000, -25000);
    vecs[2] = mkvec(5, 1000, 12, 10,   -25000,  25000,  0,     0,     5, 1000, -1472,   25000,  25000);
    vecs[3] = mkvec(2, 500,  6,  500,   100,    200,    300,   400,   2, 500,   100,    200,    300);
    vecs[4] = mkvec(3, 100,  12, 60000, 1000,  -1000,   2000, -2000,  3, 100,  -2000,   1000,  -3000);
    vecs[5] = mkvec(7, 900,  8,  50000, 0,      25736, -25736, 0,     7, 900,   25736, -25736,  0);
    vecs[6] = mkvec(1, 800,  0,  50000, -20000, 10000,  0,     0,     1, 800,  -21472,  20000,  20000);

    #2 rst = 1'b1;
    #3 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed frames, back to back at full rate.
    for (int i = 0; i < 7; i++) begin
      build_dir(vecs[i]);
      drive_frame(FL, 0);
    end
    idle(4);

    // Three back-to-back random frames with valid gaps; small magnitudes force ties.
    for (int f = 0; f < 3; f++) begin
      rand_frame((f == 1) ? 65535 : 40);
      drive_frame(FL, 3);
    end
    idle(4);

    // Reset in the middle of frame 2: partial frame discarded, counter restarts.
    rand_frame(65535);
    drive_frame(FL, 2);
    rand_frame(65535);
    drive_frame(9, 2);
    @(posedge clk); #1;
    io.valid_in = 1'b0;
    rst = 1'b1;
    #1 check_zero("midrst");
    q.delete();
    last_exp = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_frame(200);
    drive_frame(FL, 2);
    idle(4);

`ifdef PEAK_PHASE_THRESH_EN
    io.mag_thresh_in = 16'd2000;
    build_dir(vecs[0]);
    push_en = 1'b0;
    drive_frame(FL, 0);
    idle(4);
    build_dir(mkvec(5, 3000, 12, 10, 0, 4096, -4096, 25000, 5, 3000, 4096, -4096, 25000));
    push_en = 1'b1;
    drive_frame(FL, 0);
    idle(4);
    io.mag_thresh_in = 16'd0;
`endif

    check("missing_pulses", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
